// File: rtl/tc2sm_conv_if.sv
// Stream bundle for tc2sm_conv: a two's-complement input channel and a
// sign-magnitude output channel with a saturation sideband.
// Handshake: a word moves on a rising edge when valid and ready are both 1.
// A source holds data stable while valid=1 and ready=0. valid never waits on
// ready.
interface tc2sm_conv_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_out;
    logic             sat_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, sat_out, out_valid
    );

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, sat_out, out_valid
    );
endinterface

// File: rtl/tc2sm_conv.sv
// Two's-complement to sign-magnitude converter with a 2-entry output FIFO.
// Optional saturation counter enabled by macro TC2SM_SATCNT_EN.
module tc2sm_conv #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    tc2sm_conv_if.slave        bus,
    input  logic               clear,
    output logic [7:0]         sat_count,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             armed;
    logic [WIDTH-1:0] mem_data [2];
    logic             mem_sat  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-2:0] neg_mag;
    logic [WIDTH-1:0] conv_data;
    logic             conv_sat;

    // Low bits of the negation depend only on the low input bits.
    assign neg_mag = ~bus.data_in[WIDTH-2:0] + {{(WIDTH-2){1'b0}}, 1'b1};

    always_comb begin
        conv_data = bus.data_in;
        conv_sat  = 1'b0;
        if (bus.data_in[WIDTH-1]) begin
            if (bus.data_in[WIDTH-2:0] == '0) begin
                conv_data = '1;
                conv_sat  = 1'b1;
            end else begin
                conv_data = {1'b1, neg_mag};
            end
        end
    end

    assign push = bus.in_valid && armed && (state != FULL);
    assign pop  = bus.out_ready && (state != EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = armed && (state != FULL);
        bus.out_valid = (state != EMPTY);
        case (state)
            EMPTY:   if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_sat[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= conv_data;
                mem_sat[wr_ptr]  <= conv_sat;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign bus.data_out = mem_data[rd_ptr];
    assign bus.sat_out  = mem_sat[rd_ptr];
    assign state_dbg    = state;

`ifdef TC2SM_SATCNT_EN
    logic [7:0] sat_cnt;

    // Clear takes priority; the count sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= 8'd0;
        end else if (clear) begin
            sat_cnt <= 8'd0;
        end else if (pop && bus.sat_out && (sat_cnt != 8'hFF)) begin
            sat_cnt <= sat_cnt + 8'd1;
        end
    end

    assign sat_count = sat_cnt;
`else
    logic unused_clear;

    assign unused_clear = clear;
    assign sat_count    = 8'd0;
`endif
endmodule
